dma_fifo_drain: RTL

- DMA write-side engine: the consumer end of the 32-bit DMA synchronous FIFO.
- Pops words from the FIFO and issues single-beat writes on a simple req/ack memory bus.
- Writes go to consecutive word addresses from a programmed destination, until a programmed word count is reached.
- Sits between the DMA FIFO read port and the memory-bus master mux. The DMA control block drives it.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_fifo_drain.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA write-side drain engine: default widths,
// address step and the drain FSM state encoding.
package dma_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_ADDR_STEP = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/dma_fifo_drain.sv
// Consumer end of the DMA FIFO: pops words and writes them as single beats to
// consecutive addresses. Define DMA_DRAIN_TIMEOUT_EN to enable the bus-ack timeout.
module dma_fifo_drain
  import dma_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int ADDR_STEP = DEF_ADDR_STEP
`ifdef DMA_DRAIN_TIMEOUT_EN
  , parameter int TO_CYC  = 255
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_clear,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  xfer_cnt,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;
  logic              abort_pend;

`ifdef DMA_DRAIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign err = 1'b0;
`endif

  // Pop only while in POP and data is available; never when empty.
  assign fifo_rd = (state == POP) && !fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remain     <= '0;
      abort_pend <= 1'b0;
      fifo_clear <= 1'b0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      xfer_cnt   <= '0;
`ifdef DMA_DRAIN_TIMEOUT_EN
      err        <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      done       <= 1'b0;
      fifo_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= dst_addr;
            remain     <= len;
            xfer_cnt   <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b1;
`ifdef DMA_DRAIN_TIMEOUT_EN
            err        <= 1'b0;
            to_cnt     <= '0;
`endif
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= POP;
            end
          end
        end
        POP: begin
          if (abort) begin
            state      <= FIN;
            done       <= 1'b1;
            fifo_clear <= 1'b1;
          end else if (!fifo_empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          // An abort here drops the word just popped; it is never counted.
          if (abort) begin
            state      <= FIN;
            done       <= 1'b1;
            fifo_clear <= 1'b1;
          end else begin
            bus_wdata <= fifo_rdata;
            bus_addr  <= cur_addr;
            bus_req   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (abort) abort_pend <= 1'b1;
          if (bus_req && bus_ack) begin
            bus_req  <= 1'b0;
            cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
            remain   <= remain - LEN_W'(1);
            xfer_cnt <= xfer_cnt + LEN_W'(1);
`ifdef DMA_DRAIN_TIMEOUT_EN
            to_cnt   <= '0;
`endif
            if (abort || abort_pend) begin
              state      <= FIN;
              done       <= 1'b1;
              fifo_clear <= 1'b1;
            end else if (remain == LEN_W'(1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= POP;
            end
          end
`ifdef DMA_DRAIN_TIMEOUT_EN
          else if (to_cnt == TO_W'(TO_CYC - 1)) begin
            bus_req    <= 1'b0;
            err        <= 1'b1;
            fifo_clear <= 1'b1;
            done       <= 1'b1;
            to_cnt     <= '0;
            state      <= FIN;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
